sprite_line_mixer: RTL and testbench

Scanline sprite stage between the background drawer and vga_driver. During each horizontal blanking it scans an 8-entry sprite attribute table and renders the next game-window line of 16x16 sprites into a double-banked 256-pixel line buffer. During active video it composites the buffered sprite pixels over the background RGB and drives the pixdata input of vga_driver.

---
 rtl/sprite_line_mixer_pkg.sv | 53 +++++
 rtl/sprite_line_mixer_line_buffer.sv | 55 +++++
 rtl/sprite_line_mixer.sv | 194 +++++++++++++++++++
 tb/tb_sprite_line_mixer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_line_mixer_pkg.sv
// Shared types and constants for the scanline sprite mixer.
package sprite_line_mixer_pkg;

    localparam int RGB_BIT       = 12;
    localparam int VGA_POSXY_BIT = 10;
    localparam int SPR_NUM       = 8;
    localparam int SPR_IDX_BIT   = 3;
    localparam int LINE_W        = 256;
    localparam int LINE_AW       = 8;

    localparam logic [VGA_POSXY_BIT-1:0] GAME_START_POSX = 10'd0;
    localparam logic [VGA_POSXY_BIT-1:0] GAME_START_POSY = 10'd0;
    localparam logic [VGA_POSXY_BIT-1:0] WIN_X0          = GAME_START_POSX;
    localparam logic [VGA_POSXY_BIT-1:0] WIN_Y0          = GAME_START_POSY;
    localparam logic [RGB_BIT-1:0]       TRANSP_RGB      = 12'hF0F;
    localparam logic [SPR_IDX_BIT-1:0]   SPR_LAST        = 3'(SPR_NUM - 1);

    // Attribute word layout: enable, posY, posX, tile, hflip, 4 ignored bits.
    typedef struct packed {
        logic       en;
        logic [8:0] posy;
        logic [8:0] posx;
        logic [7:0] tile;
        logic       hflip;
        logic [3:0] rsvd;
    } spr_attr_t;

    typedef struct packed {
        logic               vld;
        logic [RGB_BIT-1:0] rgb;
    } lbuf_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_CHECK = 3'd2,
        ST_DRAW  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_NEXT  = 3'd5
    } spr_state_e;

    // ROM column for a screen column; mirrored sprites read right-to-left.
    function automatic logic [3:0] rom_col(input logic [3:0] col, input logic hflip);
        logic [3:0] res;
        if (hflip) begin
            res = ~col;
        end else begin
            res = col;
        end
        return res;
    endfunction

endpackage

// File: rtl/sprite_line_mixer_line_buffer.sv
// Double-banked sprite line buffer: first-writer-wins on the back bank,
// read-and-clear on the front bank, banks swapped by a toggle pulse.
module sprite_line_buffer
    import sprite_line_mixer_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               toggle_i,
    input  logic               wr_en_i,
    input  logic [LINE_AW-1:0] wr_addr_i,
    input  logic [RGB_BIT-1:0] wr_rgb_i,
    input  logic               rd_en_i,
    input  logic [LINE_AW-1:0] rd_addr_i,
    output lbuf_entry_t        rd_entry_o
);

    logic               bank_q;
    logic               back_s;
    logic               wr_ok_s;
    logic [LINE_W-1:0]  vld_q [2];
    logic [RGB_BIT-1:0] rgb_q [2][LINE_W];

    assign back_s  = ~bank_q;
    // An already-valid entry belongs to a lower-index sprite, which stays on top.
    assign wr_ok_s = wr_en_i && !vld_q[back_s][wr_addr_i];

    assign rd_entry_o = {vld_q[bank_q][rd_addr_i], rgb_q[bank_q][rd_addr_i]};

    // Bank select and valid flags; the front entry is invalidated as it is displayed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_q   <= 1'b0;
            vld_q[0] <= '0;
            vld_q[1] <= '0;
        end else begin
            if (toggle_i) begin
                bank_q <= ~bank_q;
            end
            if (wr_ok_s) begin
                vld_q[back_s][wr_addr_i] <= 1'b1;
            end
            if (rd_en_i) begin
                vld_q[bank_q][rd_addr_i] <= 1'b0;
            end
        end
    end

    // Colour storage; contents are meaningless while the matching valid flag is low.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            rgb_q[back_s][wr_addr_i] <= wr_rgb_i;
        end
    end

endmodule

// File: rtl/sprite_line_mixer.sv
// Scanline sprite stage: renders the next window line during hblank and
// overlays the buffered sprite pixels on the background during active video.
module sprite_line_mixer
    import sprite_line_mixer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [VGA_POSXY_BIT-1:0] vgaPosX,
    input  logic [VGA_POSXY_BIT-1:0] vgaPosY,
    input  logic                     lineStart,
    input  logic [RGB_BIT-1:0]       bgRgbIn,
    output logic [SPR_IDX_BIT-1:0]   sprAttrAddr,
    input  logic [31:0]              sprAttrData,
    output logic [15:0]              sprRomAddr,
    input  logic [RGB_BIT-1:0]       sprRomData,
    output logic [RGB_BIT-1:0]       rgbOut,
    output logic                     busy,
    output logic                     overrun
);

    spr_state_e             state_q, state_d;
    logic [SPR_IDX_BIT-1:0] idx_q, idx_d;
    logic [3:0]             col_q, col_d;
    logic [8:0]             nexty_q, nexty_d;
    logic [8:0]             posx_q, posx_d;
    logic [7:0]             tile_q, tile_d;
    logic                   hflip_q, hflip_d;
    logic [3:0]             row_q, row_d;
    logic [15:0]            rom_addr_q, rom_addr_d;
    logic                   wr_vld_q, wr_vld_d;
    logic [8:0]             wr_x_q, wr_x_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;
    logic [RGB_BIT-1:0]     rgb_q, rgb_d;

    spr_attr_t              attr_s;
    logic [8:0]             row_full_s;
    logic [VGA_POSXY_BIT-1:0] liney_s;
    logic [VGA_POSXY_BIT:0] localx_s;
    logic                   in_win_s;
    logic                   wr_en_s;
    lbuf_entry_t            rd_entry_s;
    logic                   attr_unused_s;

    assign attr_s        = spr_attr_t'(sprAttrData);
    assign row_full_s    = nexty_q - attr_s.posy;
    assign liney_s       = vgaPosY - WIN_Y0 + 10'd1;
    assign attr_unused_s = ^{attr_s.rsvd, liney_s[VGA_POSXY_BIT-1]};

    // Extra top bit catches positions left of the window start.
    assign localx_s = {1'b0, vgaPosX} - {1'b0, WIN_X0};
    assign in_win_s = (localx_s[VGA_POSXY_BIT:LINE_AW] == '0);

    // Right-clipped and transparent pixels never reach the buffer.
    assign wr_en_s = wr_vld_q && (wr_x_q[LINE_AW] == 1'b0) && (sprRomData != TRANSP_RGB);

    assign sprAttrAddr = idx_q;
    assign sprRomAddr  = rom_addr_q;
    assign rgbOut      = rgb_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

    sprite_line_buffer u_lbuf (
        .clk        (clk),
        .rstn       (rstn),
        .toggle_i   (lineStart),
        .wr_en_i    (wr_en_s),
        .wr_addr_i  (wr_x_q[LINE_AW-1:0]),
        .wr_rgb_i   (sprRomData),
        .rd_en_i    (in_win_s),
        .rd_addr_i  (localx_s[LINE_AW-1:0]),
        .rd_entry_o (rd_entry_s)
    );

    // Render sequencer: next state, ROM address one cycle ahead, write pipeline.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        col_d      = col_q;
        nexty_d    = nexty_q;
        posx_d     = posx_q;
        tile_d     = tile_q;
        hflip_d    = hflip_q;
        row_d      = row_q;
        rom_addr_d = rom_addr_q;
        wr_vld_d   = 1'b0;
        wr_x_d     = wr_x_q;
        overrun_d  = overrun_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_FETCH: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                posx_d  = attr_s.posx;
                tile_d  = attr_s.tile;
                hflip_d = attr_s.hflip;
                row_d   = row_full_s[3:0];
                if (attr_s.en && (row_full_s[8:4] == 5'd0)) begin
                    state_d    = ST_DRAW;
                    col_d      = 4'd0;
                    rom_addr_d = {attr_s.tile, row_full_s[3:0], rom_col(4'd0, attr_s.hflip)};
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_DRAW: begin
                wr_vld_d   = 1'b1;
                wr_x_d     = posx_q + {5'd0, col_q};
                rom_addr_d = {tile_q, row_q, rom_col(col_q + 4'd1, hflip_q)};
                if (col_q == 4'd15) begin
                    state_d = ST_FLUSH;
                end else begin
                    col_d = col_q + 4'd1;
                end
            end
            ST_FLUSH, ST_NEXT: begin
                if (idx_q == SPR_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new line always wins; an unfinished render is abandoned and flagged.
        if (lineStart) begin
            if (state_q != ST_IDLE) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
            state_d  = ST_FETCH;
            idx_d    = '0;
            nexty_d  = liney_s[8:0];
            wr_vld_d = 1'b0;
        end else begin
            nexty_d = nexty_d;
        end
    end

    // Busy flag and composited output, both registered.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        if (in_win_s && rd_entry_s.vld) begin
            rgb_d = rd_entry_s.rgb;
        end else begin
            rgb_d = bgRgbIn;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            col_q      <= 4'd0;
            nexty_q    <= 9'd0;
            posx_q     <= 9'd0;
            tile_q     <= 8'd0;
            hflip_q    <= 1'b0;
            row_q      <= 4'd0;
            rom_addr_q <= 16'd0;
            wr_vld_q   <= 1'b0;
            wr_x_q     <= 9'd0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
            rgb_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            col_q      <= col_d;
            nexty_q    <= nexty_d;
            posx_q     <= posx_d;
            tile_q     <= tile_d;
            hflip_q    <= hflip_d;
            row_q      <= row_d;
            rom_addr_q <= rom_addr_d;
            wr_vld_q   <= wr_vld_d;
            wr_x_q     <= wr_x_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
            rgb_q      <= rgb_d;
        end
    end

endmodule

// File: tb/tb_sprite_line_mixer.sv
// Bench for sprite_line_mixer: attribute RAM and sprite ROM models, a
// line-level reference model, directed plan scenarios and random lines.
module tb_sprite_line_mixer;
    import sprite_line_mixer_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [9:0]  vgaPosX, vgaPosY;
    logic        lineStart;
    logic [11:0] bgRgbIn;
    logic [2:0]  sprAttrAddr;
    logic [31:0] sprAttrData;
    logic [15:0] sprRomAddr;
    logic [11:0] sprRomData;
    logic [11:0] rgbOut;
    logic        busy, overrun;

    logic [31:0] attr_mem [8];
    logic [11:0] rom_mem [65536];

    // Reference line buffer: two banks, index of the displayed one.
    bit          mvld [2][256];
    logic [11:0] mrgb [2][256];
    int          mfront;

    logic [11:0] got [256];
    logic [11:0] bgv [256];

    int checks   = 0;
    int failures = 0;

    sprite_line_mixer dut (
        .clk        (clk),
        .rstn       (rstn),
        .vgaPosX    (vgaPosX),
        .vgaPosY    (vgaPosY),
        .lineStart  (lineStart),
        .bgRgbIn    (bgRgbIn),
        .sprAttrAddr(sprAttrAddr),
        .sprAttrData(sprAttrData),
        .sprRomAddr (sprRomAddr),
        .sprRomData (sprRomData),
        .rgbOut     (rgbOut),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories with one cycle of latency.
    always @(posedge clk) begin
        sprAttrData <= attr_mem[sprAttrAddr];
        sprRomData  <= rom_mem[sprRomAddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_attr(input bit en, input int py, input int px,
                                            input int tile, input bit hf);
        return {en, py[8:0], px[8:0], tile[7:0], hf, 4'b1010};
    endfunction

    function automatic void clear_attrs();
        for (int i = 0; i < 8; i++) attr_mem[i] = 32'h0000_0000;
    endfunction

    function automatic void model_reset();
        mfront = 0;
        for (int b = 0; b < 2; b++)
            for (int x = 0; x < 256; x++) mvld[b][x] = 1'b0;
    endfunction

    // Swap banks, then paint every visible sprite pixel into the new back bank;
    // walking sprites from index 0 and never overwriting keeps sprite 0 on top.
    function automatic void model_linestart(input int ny);
        int back;
        mfront = mfront ^ 1;
        back   = mfront ^ 1;
        for (int s = 0; s < 8; s++) begin
            logic [31:0] a;
            int py, px, tile, row, x, rc;
            bit hf;
            logic [11:0] pix;
            a    = attr_mem[s];
            py   = int'(a[30:22]);
            px   = int'(a[21:13]);
            tile = int'(a[12:5]);
            hf   = a[4];
            row  = (ny - py) & 511;
            if (a[31] && row < 16) begin
                for (int c = 0; c < 16; c++) begin
                    x  = (px + c) & 511;
                    rc = hf ? 15 - c : c;
                    pix = rom_mem[tile * 256 + row * 16 + rc];
                    if (x < 256 && pix != 12'hF0F && !mvld[back][x]) begin
                        mvld[back][x] = 1'b1;
                        mrgb[back][x] = pix;
                    end
                end
            end
        end
    endfunction

    task automatic pulse_ls(input int py);
        vgaPosY   = py[9:0];
        vgaPosX   = 10'd700;
        lineStart = 1'b1;
        step();
        lineStart = 1'b0;
        chk("busy_after_linestart", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 400) begin
            step();
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic render(input int py);
        pulse_ls(py);
        model_linestart((py + 1) & 511);
        wait_idle("render_done");
    endtask

    // Render the current attributes for nextY = py+1, swap them to the front
    // with an empty render, then scan the whole window and a little beyond.
    task automatic show_line(input int py);
        render(py);
        clear_attrs();
        render(300);
        for (int x = 0; x < 260; x++) begin
            logic [11:0] bg, exp;
            bg      = 12'($urandom);
            vgaPosX = 10'(x);
            bgRgbIn = bg;
            step();
            exp = bg;
            if (x < 256) begin
                if (mvld[mfront][x]) exp = mrgb[mfront][x];
                mvld[mfront][x] = 1'b0;
                got[x] = rgbOut;
                bgv[x] = bg;
            end
            chk("pixel", {20'd0, rgbOut}, {20'd0, exp});
        end
        vgaPosX = 10'd700;
    endtask

    initial begin
        rstn      = 1'b0;
        lineStart = 1'b0;
        vgaPosX   = 10'd700;
        vgaPosY   = 10'd0;
        bgRgbIn   = 12'h000;
        clear_attrs();
        model_reset();
        for (int a = 0; a < 65536; a++) begin
            if ($urandom_range(0, 7) == 0) rom_mem[a] = 12'hF0F;
            else                           rom_mem[a] = 12'($urandom);
        end
        for (int a = 0; a < 256; a++) begin
            rom_mem[256 * 1 + a] = 12'h0F0;
            rom_mem[256 * 2 + a] = 12'hF00;
            rom_mem[256 * 3 + a] = 12'h00F;
            if (a % 16 == 0)      rom_mem[256 * 4 + a] = 12'h111;
            else if (a % 16 == 5) rom_mem[256 * 4 + a] = 12'hF0F;
            else                  rom_mem[256 * 4 + a] = 12'h222;
        end

        step(); step(); step();
        chk("reset_rgbOut", {20'd0, rgbOut}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        chk("reset_attr_addr", {29'd0, sprAttrAddr}, 32'd0);
        chk("reset_rom_addr", {16'd0, sprRomAddr}, 32'd0);
        rstn = 1'b1;
        step();

        // Single sprite at posX=20 on line 10.
        clear_attrs();
        attr_mem[0] = mk_attr(1'b1, 10, 20, 1, 1'b0);
        show_line(9);
        chk("t1_x20", {20'd0, got[20]}, 32'h0F0);
        chk("t1_x35", {20'd0, got[35]}, 32'h0F0);
        chk("t1_x19_bg", {20'd0, got[19]}, {20'd0, bgv[19]});
        chk("t1_x36_bg", {20'd0, got[36]}, {20'd0, bgv[36]});

        // Overlap: sprite 0 stays on top.
        clear_attrs();
        attr_mem[0] = mk_attr(1'b1, 10, 40, 2, 1'b0);
        attr_mem[1] = mk_attr(1'b1, 10, 48, 3, 1'b0);
        show_line(9);
        chk("t2_overlap", {20'd0, got[50]}, 32'hF00);
        chk("t2_spr1_only", {20'd0, got[56]}, 32'h00F);

        // Right clip, no wrap to the left edge.
        clear_attrs();
        attr_mem[0] = mk_attr(1'b1, 10, 250, 1, 1'b0);
        show_line(9);
        chk("t3_x255", {20'd0, got[255]}, 32'h0F0);
        chk("t3_x0_bg", {20'd0, got[0]}, {20'd0, bgv[0]});
        chk("t3_x9_bg", {20'd0, got[9]}, {20'd0, bgv[9]});

        // Horizontal flip and transparency.
        clear_attrs();
        attr_mem[0] = mk_attr(1'b1, 10, 100, 4, 1'b1);
        show_line(9);
        chk("t4_flip_col0", {20'd0, got[115]}, 32'h111);
        chk("t4_transp_bg", {20'd0, got[110]}, {20'd0, bgv[110]});
        chk("t4_x100", {20'd0, got[100]}, 32'h222);

        // Empty line after sprite lines: read-and-clear leaves pure background.
        clear_attrs();
        show_line(9);
        for (int x = 0; x < 256; x += 37)
            chk("t6_bg", {20'd0, got[x]}, {20'd0, bgv[x]});

        // Random lines against the reference model.
        for (int t = 0; t < 6; t++) begin
            int py, ny;
            py = $urandom_range(0, 470);
            ny = (py + 1) & 511;
            for (int i = 0; i < 8; i++)
                attr_mem[i] = mk_attr($urandom_range(0, 3) != 0,
                                      (ny - $urandom_range(0, 19)) & 511,
                                      $urandom_range(0, 300),
                                      $urandom_range(16, 255),
                                      $urandom_range(0, 1) == 1);
            show_line(py);
        end

        // Overrun: eight hits need 152 cycles; restart after 100.
        for (int i = 0; i < 8; i++) attr_mem[i] = mk_attr(1'b1, 10, i * 30, 1, 1'b0);
        pulse_ls(9);
        repeat (99) step();
        chk("ovr_before", {31'd0, overrun}, 32'd0);
        chk("ovr_still_busy", {31'd0, busy}, 32'd1);
        pulse_ls(9);
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        wait_idle("ovr_no_hang");
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Reset in the middle of a render.
        pulse_ls(9);
        repeat (5) step();
        rstn = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_overrun", {31'd0, overrun}, 32'd0);
        chk("midrst_rgb", {20'd0, rgbOut}, 32'd0);
        chk("midrst_rom_addr", {16'd0, sprRomAddr}, 32'd0);
        chk("midrst_attr_addr", {29'd0, sprAttrAddr}, 32'd0);
        step(); step();
        rstn = 1'b1;
        model_reset();
        step();

        // Both banks must come back empty.
        clear_attrs();
        show_line(9);
        clear_attrs();
        attr_mem[2] = mk_attr(1'b1, 10, 200, 3, 1'b0);
        show_line(9);
        chk("post_rst_x200", {20'd0, got[200]}, 32'h00F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
